// File: rtl/axi_ram_pkg.sv
// axi_ram_pkg: shared types and helpers for axi_ram_bridge.
// Contents: burst encoding, response codes, write/read FSM state enums,
// and burst_err(), which flags bursts that must run as INCR with SLVERR.
// Build option: define AXI_RAM_BRIDGE_WRAP_EN to enable real WRAP bursts.
package axi_ram_pkg;
    typedef enum logic [1:0] {FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10} burst_e;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_BURST} r_state_e;
`ifdef AXI_RAM_BRIDGE_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif
    // Reserved bursts and unsupported WRAP lengths run as INCR but report SLVERR.
    function automatic logic burst_err(input logic [1:0] burst, input logic [7:0] len);
        return burst == 2'b11 ||
               (burst == WRAP && !(WRAP_EN && len inside {8'd1, 8'd3, 8'd7, 8'd15}));
    endfunction
endpackage

// File: rtl/axi_ram_addr_gen.sv
// axi_ram_addr_gen: combinational next beat address.
// Ports: addr_i current beat address, burst_i burst type, len_i AXI length,
//        next_o address of the following beat.
// Build option: AXI_RAM_BRIDGE_WRAP_EN (via axi_ram_pkg) enables WRAP wrapping.
module axi_ram_addr_gen
    import axi_ram_pkg::*;
#(
    parameter int AW   = 32,
    parameter int STEP = 16
) (
    input  logic [AW-1:0] addr_i,
    input  logic [1:0]    burst_i,
    input  logic [7:0]    len_i,
    output logic [AW-1:0] next_o
);
    logic [AW-1:0] incr;
    logic [AW-1:0] mask;
    assign incr = addr_i + AW'(STEP);
    // Wrap window is (len+1) beats; only its low bits advance.
    assign mask = (AW'(len_i) + AW'(1)) * AW'(STEP) - AW'(1);
    assign next_o = burst_i == FIXED ? addr_i :
                    (burst_i == WRAP && !burst_err(burst_i, len_i)) ? (addr_i & ~mask) | (incr & mask) :
                    incr;
endmodule

// File: rtl/axi_ram_bridge.sv
// axi_ram_bridge: AXI4 slave to single-cycle RAM bridge, independent read/write FSMs.
// Ports: clk/rstn (async active-low); AXI4 AW/W/B/AR/R slave channels (s_axi_*);
//        RAM read port ren/raddr/rdata (rdata valid in the ren cycle);
//        RAM write port wen/waddr/wdata/wstrb (committed on the clk edge with wen=1).
// Build option: AXI_RAM_BRIDGE_WRAP_EN enables WRAP bursts; otherwise WRAP runs as INCR with SLVERR.
module axi_ram_bridge
    import axi_ram_pkg::*;
#(
    parameter int AXI_WIDTH      = 128,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 6
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [AXI_ID_WIDTH-1:0]   s_axi_awid,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]                s_axi_awlen,
    input  logic [1:0]                s_axi_awburst,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [AXI_WIDTH-1:0]      s_axi_wdata,
    input  logic [AXI_WIDTH/8-1:0]    s_axi_wstrb,
    input  logic                      s_axi_wlast,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    output logic [AXI_ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    input  logic [AXI_ID_WIDTH-1:0]   s_axi_arid,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]                s_axi_arlen,
    input  logic [1:0]                s_axi_arburst,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [AXI_ID_WIDTH-1:0]   s_axi_rid,
    output logic [AXI_WIDTH-1:0]      s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rlast,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    output logic                      ren,
    output logic [AXI_ADDR_WIDTH-1:0] raddr,
    input  logic [AXI_WIDTH-1:0]      rdata,
    output logic                      wen,
    output logic [AXI_ADDR_WIDTH-1:0] waddr,
    output logic [AXI_WIDTH-1:0]      wdata,
    output logic [AXI_WIDTH/8-1:0]    wstrb
);
    localparam int STEP = AXI_WIDTH / 8;
    localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN = ~AXI_ADDR_WIDTH'(STEP - 1);

    w_state_e                  w_state_q;
    logic [AXI_ID_WIDTH-1:0]   aw_id_q;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr_q, w_addr_d;
    logic [7:0]                aw_len_q, w_cnt_q;
    logic [1:0]                aw_burst_q, bresp_q;
    logic                      w_err_q, wen_q;
    logic [AXI_ADDR_WIDTH-1:0] waddr_q;
    logic [AXI_WIDTH-1:0]      wdata_q;
    logic [AXI_WIDTH/8-1:0]    wstrb_q;
    logic                      w_last, w_bad;

    r_state_e                  r_state_q;
    logic [AXI_ID_WIDTH-1:0]   ar_id_q, rid_q;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr_q, r_addr_d;
    logic [7:0]                ar_len_q, r_cnt_q;
    logic [1:0]                ar_burst_q, rresp_q;
    logic                      ar_err_q, rvalid_q, rlast_q;
    logic [AXI_WIDTH-1:0]      rdata_q;
    logic                      r_issue;

    axi_ram_addr_gen #(.AW(AXI_ADDR_WIDTH), .STEP(STEP)) u_w_addr (
        .addr_i (aw_addr_q),
        .burst_i(aw_burst_q),
        .len_i  (aw_len_q),
        .next_o (w_addr_d)
    );

    axi_ram_addr_gen #(.AW(AXI_ADDR_WIDTH), .STEP(STEP)) u_r_addr (
        .addr_i (ar_addr_q),
        .burst_i(ar_burst_q),
        .len_i  (ar_len_q),
        .next_o (r_addr_d)
    );

    // Ready is gated by rstn so it is low during reset and high right after release.
    assign s_axi_awready = rstn && w_state_q == W_IDLE;
    assign s_axi_wready  = w_state_q == W_DATA;
    assign s_axi_bvalid  = w_state_q == W_RESP;
    assign s_axi_bid     = aw_id_q;
    assign s_axi_bresp   = bresp_q;
    assign wen   = wen_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;
    assign wstrb = wstrb_q;
    assign w_last = w_cnt_q == aw_len_q;
    assign w_bad  = s_axi_wlast != w_last;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state_q  <= W_IDLE;
            aw_id_q    <= '0;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            aw_burst_q <= '0;
            w_cnt_q    <= '0;
            w_err_q    <= 1'b0;
            bresp_q    <= OKAY;
            wen_q      <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
        end else begin
            wen_q <= 1'b0;
            case (w_state_q)
                W_IDLE: if (s_axi_awvalid) begin
                    aw_id_q    <= s_axi_awid;
                    aw_addr_q  <= s_axi_awaddr & ALIGN;
                    aw_len_q   <= s_axi_awlen;
                    aw_burst_q <= s_axi_awburst;
                    w_err_q    <= burst_err(s_axi_awburst, s_axi_awlen);
                    w_cnt_q    <= '0;
                    w_state_q  <= W_DATA;
                end
                W_DATA: if (s_axi_wvalid) begin
                    wen_q     <= 1'b1;
                    waddr_q   <= aw_addr_q;
                    wdata_q   <= s_axi_wdata;
                    wstrb_q   <= s_axi_wstrb;
                    aw_addr_q <= w_addr_d;
                    w_cnt_q   <= w_cnt_q + 8'd1;
                    w_err_q   <= w_err_q | w_bad;
                    if (w_last) begin
                        bresp_q   <= (w_err_q | w_bad) ? SLVERR : OKAY;
                        w_state_q <= W_RESP;
                    end
                end
                W_RESP: if (s_axi_bready) w_state_q <= W_IDLE;
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    // Issue when the output slot is free or being drained, unless the last beat is already out.
    assign r_issue = r_state_q == R_BURST && (!rvalid_q || (s_axi_rready && !rlast_q));
    assign s_axi_arready = rstn && r_state_q == R_IDLE;
    assign s_axi_rid    = rid_q;
    assign s_axi_rdata  = rdata_q;
    assign s_axi_rresp  = rresp_q;
    assign s_axi_rlast  = rlast_q;
    assign s_axi_rvalid = rvalid_q;
    assign ren   = r_issue;
    assign raddr = ar_addr_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state_q  <= R_IDLE;
            ar_id_q    <= '0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_burst_q <= '0;
            ar_err_q   <= 1'b0;
            r_cnt_q    <= '0;
            rid_q      <= '0;
            rdata_q    <= '0;
            rresp_q    <= OKAY;
            rlast_q    <= 1'b0;
            rvalid_q   <= 1'b0;
        end else begin
            case (r_state_q)
                R_IDLE: if (s_axi_arvalid) begin
                    ar_id_q    <= s_axi_arid;
                    ar_addr_q  <= s_axi_araddr & ALIGN;
                    ar_len_q   <= s_axi_arlen;
                    ar_burst_q <= s_axi_arburst;
                    ar_err_q   <= burst_err(s_axi_arburst, s_axi_arlen);
                    r_cnt_q    <= '0;
                    r_state_q  <= R_BURST;
                end
                R_BURST: if (r_issue) begin
                    rvalid_q  <= 1'b1;
                    rdata_q   <= rdata;
                    rid_q     <= ar_id_q;
                    rresp_q   <= ar_err_q ? SLVERR : OKAY;
                    rlast_q   <= r_cnt_q == ar_len_q;
                    ar_addr_q <= r_addr_d;
                    r_cnt_q   <= r_cnt_q + 8'd1;
                end else if (s_axi_rready) begin
                    rvalid_q <= 1'b0;
                    rlast_q  <= 1'b0;
                    if (rlast_q) r_state_q <= R_IDLE;
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_ram_bridge.sv
// tb_axi_ram_bridge: directed self-checking bench for axi_ram_bridge with a behavioural RAM.
module tb_axi_ram_bridge;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [5:0]   s_axi_awid, s_axi_bid, s_axi_arid, s_axi_rid;
    logic [31:0]  s_axi_awaddr, s_axi_araddr, raddr, waddr;
    logic [7:0]   s_axi_awlen, s_axi_arlen;
    logic [1:0]   s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
    logic         s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
    logic         s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
    logic         s_axi_rlast, s_axi_rvalid, s_axi_rready, ren, wen;
    logic [127:0] s_axi_wdata, s_axi_rdata, rdata, wdata;
    logic [15:0]  s_axi_wstrb, wstrb;

    axi_ram_bridge dut (
        .clk(clk), .rstn(rstn),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .ren(ren), .raddr(raddr), .rdata(rdata),
        .wen(wen), .waddr(waddr), .wdata(wdata), .wstrb(wstrb)
    );

    function automatic logic [127:0] pat(input logic [7:0] i);
        return {4{8'hC0, 8'h5A, i, ~i}};
    endfunction

    function automatic logic [127:0] wd(input logic [7:0] seed, input int i);
        return {4{seed + 8'(i), 24'h00BEEF}};
    endfunction

    // RAM model: unwritten beats read back as pat(index).
    logic [127:0] mem [256];
    logic [255:0] written;
    logic [7:0]   ri, wi;
    logic [127:0] wbase;
    assign ri = raddr[11:4];
    assign wi = waddr[11:4];
    assign rdata = written[ri] ? mem[ri] : pat(ri);
    assign wbase = written[wi] ? mem[wi] : pat(wi);
    always @(posedge clk) begin
        if (!rstn) written <= '0;
        else if (wen) begin
            for (int b = 0; b < 16; b++) mem[wi][b*8 +: 8] <= wstrb[b] ? wdata[b*8 +: 8] : wbase[b*8 +: 8];
            written[wi] <= 1'b1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0]  rq[$], wq[$];
    int           wcyc[$];
    logic [127:0] rdq[$];
    logic         rlq[$];
    logic [1:0]   rrq[$];
    always @(negedge clk) begin
        if (wen) begin wq.push_back(waddr); wcyc.push_back(cyc); end
        if (ren) rq.push_back(raddr);
        if (s_axi_rvalid && s_axi_rready) begin
            rdq.push_back(s_axi_rdata); rlq.push_back(s_axi_rlast); rrq.push_back(s_axi_rresp);
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic clear();
        rq.delete(); wq.delete(); wcyc.delete(); rdq.delete(); rlq.delete(); rrq.delete();
    endtask

    task automatic send_aw(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b, input logic [5:0] id);
        int t = 0;
        s_axi_awaddr = a; s_axi_awlen = l; s_axi_awburst = b; s_axi_awid = id; s_axi_awvalid = 1'b1;
        while (!s_axi_awready && t < 20) begin step(); t++; end
        check("awready", s_axi_awready, 1);
        step();
        s_axi_awvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b, input logic [5:0] id);
        int t = 0;
        s_axi_araddr = a; s_axi_arlen = l; s_axi_arburst = b; s_axi_arid = id; s_axi_arvalid = 1'b1;
        while (!s_axi_arready && t < 20) begin step(); t++; end
        check("arready", s_axi_arready, 1);
        step();
        s_axi_arvalid = 1'b0;
    endtask

    task automatic send_w(input int n, input int last_at, input logic [7:0] seed);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            s_axi_wdata = wd(seed, i); s_axi_wstrb = '1; s_axi_wlast = (i == last_at); s_axi_wvalid = 1'b1;
            while (!s_axi_wready && t < 20) begin step(); t++; end
            step();
        end
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    endtask

    task automatic get_b(output logic [1:0] resp, output logic [5:0] id);
        int t = 0;
        while (!s_axi_bvalid && t < 50) begin step(); t++; end
        check("bvalid", s_axi_bvalid, 1);
        resp = s_axi_bresp; id = s_axi_bid;
        s_axi_bready = 1'b1;
        step();
        s_axi_bready = 1'b0;
    endtask

    task automatic get_r(input int n, input bit rnd);
        int t = 0;
        while (rdq.size() < n && t < 300) begin
            s_axi_rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            step(); t++;
        end
        s_axi_rready = 1'b0;
        check("r_beats", rdq.size(), n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [1:0]  bresp;
        logic [5:0]  bid;
        logic [31:0] wexp [4];
        int n;
        s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awburst = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
        s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arburst = '0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b0;
        #12;
        check("rst_awready", s_axi_awready, 0);
        check("rst_arready", s_axi_arready, 0);
        check("rst_wready", s_axi_wready, 0);
        check("rst_bvalid", s_axi_bvalid, 0);
        check("rst_rvalid", s_axi_rvalid, 0);
        check("rst_ren_wen", {ren, wen}, 0);
        check("rst_rdata", s_axi_rdata, 0);
        @(posedge clk); #1 rstn = 1'b1;
        #1 check("rel_awready", s_axi_awready, 1);
        step();

        // INCR write of four beats, no stalls
        clear();
        send_aw(32'h100, 8'd3, 2'b01, 6'd5);
        send_w(4, 3, 8'h10);
        get_b(bresp, bid);
        check("w1_bresp", bresp, 2'b00);
        check("w1_bid", bid, 6'd5);
        check("w1_wen_cnt", wq.size(), 4);
        for (int i = 0; i < 4 && i < wq.size(); i++) begin
            check($sformatf("w1_waddr%0d", i), wq[i], 32'h100 + 32'(i) * 32'h10);
            check($sformatf("w1_wcyc%0d", i), wcyc[i] - wcyc[0], i);
        end

        // read back what was written
        clear();
        send_ar(32'h100, 8'd3, 2'b01, 6'd7);
        get_r(4, 1'b0);
        for (int i = 0; i < 4 && i < rdq.size(); i++) check($sformatf("rb_data%0d", i), rdq[i], wd(8'h10, i));
        check("rb_rid", s_axi_rid, 6'd7);

        // unaligned INCR read
        clear();
        send_ar(32'h205, 8'd1, 2'b01, 6'd9);
        get_r(2, 1'b0);
        check("r2_arready", s_axi_arready, 1);
        check("r2_ren_cnt", rq.size(), 2);
        if (rq.size() == 2 && rdq.size() == 2) begin
            check("r2_raddr0", rq[0], 32'h200);
            check("r2_raddr1", rq[1], 32'h210);
            check("r2_data0", rdq[0], pat(8'h20));
            check("r2_data1", rdq[1], pat(8'h21));
            check("r2_rlast", {rlq[0], rlq[1]}, 2'b01);
            check("r2_rresp", {rrq[0], rrq[1]}, 4'b0000);
        end

        // len 7 read with random back-pressure
        clear();
        send_ar(32'h400, 8'd7, 2'b01, 6'd1);
        get_r(8, 1'b1);
        repeat (3) step();
        check("r3_ren_cnt", rq.size(), 8);
        check("r3_beat_cnt", rdq.size(), 8);
        for (int i = 0; i < 8 && i < rdq.size(); i++) begin
            check($sformatf("r3_data%0d", i), rdq[i], pat(8'h40 + 8'(i)));
            check($sformatf("r3_last%0d", i), rlq[i], i == 7);
        end

        // WRAP read at 0x130 len 3
        clear();
        send_ar(32'h130, 8'd3, 2'b10, 6'd2);
        get_r(4, 1'b0);
`ifdef AXI_RAM_BRIDGE_WRAP_EN
        wexp = '{32'h130, 32'h100, 32'h110, 32'h120};
        bresp = 2'b00;
`else
        wexp = '{32'h130, 32'h140, 32'h150, 32'h160};
        bresp = 2'b10;
`endif
        check("r4_ren_cnt", rq.size(), 4);
        for (int i = 0; i < 4 && i < rq.size() && i < rrq.size(); i++) begin
            check($sformatf("r4_raddr%0d", i), rq[i], wexp[i]);
            check($sformatf("r4_rresp%0d", i), rrq[i], bresp);
        end
        if (rdq.size() > 0) check("r4_data0", rdq[0], wd(8'h10, 3));

        // early wlast: all four beats still written, SLVERR
        clear();
        send_aw(32'h500, 8'd3, 2'b01, 6'd3);
        send_w(4, 1, 8'h50);
        get_b(bresp, bid);
        check("w2_bresp", bresp, 2'b10);
        check("w2_wen_cnt", wq.size(), 4);
        if (wq.size() == 4) check("w2_waddr3", wq[3], 32'h530);

        // reserved burst 2'b11 reads as INCR with SLVERR
        clear();
        send_ar(32'h300, 8'd1, 2'b11, 6'd4);
        get_r(2, 1'b0);
        if (rq.size() == 2 && rrq.size() == 2) begin
            check("r5_raddr1", rq[1], 32'h310);
            check("r5_rresp", {rrq[0], rrq[1]}, 4'b1010);
        end

        // FIXED write then FIXED read: last beat wins
        clear();
        send_aw(32'h600, 8'd2, 2'b00, 6'd6);
        send_w(3, 2, 8'h60);
        get_b(bresp, bid);
        check("w3_bresp", bresp, 2'b00);
        check("w3_wen_cnt", wq.size(), 3);
        for (int i = 0; i < wq.size(); i++) check($sformatf("w3_waddr%0d", i), wq[i], 32'h600);
        clear();
        send_ar(32'h600, 8'd0, 2'b00, 6'd6);
        get_r(1, 1'b0);
        if (rdq.size() == 1) begin
            check("r6_data", rdq[0], wd(8'h60, 2));
            check("r6_rlast", rlq[0], 1);
        end

        // reset during beat 2 of a len 7 read
        clear();
        send_ar(32'h700, 8'd7, 2'b01, 6'd8);
        s_axi_rready = 1'b1;
        step();
        step();
        check("rr_ren_pre", ren, 1);
        check("rr_rvalid_pre", s_axi_rvalid, 1);
        rstn = 1'b0;
        #1;
        check("rr_rvalid", s_axi_rvalid, 0);
        check("rr_ren", ren, 0);
        check("rr_arready_rst", s_axi_arready, 0);
        n = rq.size();
        step();
        step();
        rstn = 1'b1;
        #1;
        check("rr_arready_rel", s_axi_arready, 1);
        check("rr_awready_rel", s_axi_awready, 1);
        step();
        check("rr_arready_next", s_axi_arready, 1);
        step();
        check("rr_no_ren", rq.size(), n);
        check("rr_no_wen", wq.size(), 0);
        s_axi_rready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_ram_bridge.md
AXI_RAM_BRIDGE -- requirements
Module: axi_ram_bridge

Interface
REQ-001 SHALL have parameter AXI_WIDTH, default 128, data-beat width in bits (multiple of 8).
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 32, byte-address width.
REQ-003 SHALL have parameter AXI_ID_WIDTH, default 6, transaction-ID width.
REQ-004 SHALL have ports: clk in 1, single clock; rstn in 1, reset, asynchronous, active-low.
REQ-005 SHALL have AXI4 slave AW ports: s_axi_awid/awaddr/awlen[7:0]/awburst[1:0]/awvalid in; s_axi_awready out.
REQ-006 SHALL have AXI4 slave W ports: s_axi_wdata/wstrb/wlast/wvalid in; s_axi_wready out.
REQ-007 SHALL have AXI4 slave B ports: s_axi_bid/bresp[1:0]/bvalid out; s_axi_bready in.
REQ-008 SHALL have AXI4 slave AR ports: s_axi_arid/araddr/arlen[7:0]/arburst[1:0]/arvalid in; s_axi_arready out.
REQ-009 SHALL have AXI4 slave R ports: s_axi_rid/rdata/rresp[1:0]/rlast/rvalid out; s_axi_rready in.
REQ-010 SHALL have RAM ports: ren out 1; raddr out AXI_ADDR_WIDTH; rdata in AXI_WIDTH, valid combinationally in the same cycle as ren.
REQ-011 SHALL have RAM ports: wen out 1; waddr out AXI_ADDR_WIDTH; wdata out AXI_WIDTH; wstrb out AXI_WIDTH/8; the RAM commits the write on the clk edge where wen=1.

Function
REQ-012 SHALL treat every beat as full width; awsize/arsize are not ports, address step = AXI_WIDTH/8, and start addresses are aligned down to the beat.
REQ-013 SHALL support burst FIXED (address constant), INCR (address += step), and WRAP (per REQ-031/032); burst 2'b11 SHALL be handled as INCR with resp SLVERR (2'b10).
REQ-014 SHALL run independent read and write FSMs; concurrent reads and writes proceed in parallel.
REQ-015 Write FSM states: W_IDLE, W_DATA, W_RESP; awready=1 only in W_IDLE; AW handshake latches id/addr/len/burst and moves to W_DATA.
REQ-016 In W_DATA, wready=1; each W handshake SHALL drive wen=1, waddr=current address, wdata/wstrb=beat in the next cycle (one-cycle registered latency), then advance the address.
REQ-017 The beat with count==awlen SHALL move to W_RESP regardless of wlast; a wlast/count mismatch SHALL set bresp=SLVERR, otherwise OKAY.
REQ-018 In W_RESP, bvalid=1 with bid=latched id until bready, then W_IDLE; bvalid SHALL not drop before the handshake.
REQ-019 Read FSM states: R_IDLE, R_BURST; arready=1 only in R_IDLE; AR handshake latches id/addr/len/burst.
REQ-020 In R_BURST, when rvalid=0 or rready=1, the FSM SHALL assert ren with raddr=current address and register rdata into s_axi_rdata, giving rvalid=1 in the next cycle; otherwise ren=0 and R outputs hold.
REQ-021 rlast SHALL be 1 on the beat with count==arlen; the R handshake on that beat returns to R_IDLE; the 256-beat burst (len=255) SHALL complete without counter overflow.
REQ-022 Sustained throughput SHALL be one beat per clock on both R and W when the master never stalls.
REQ-023 ren=0 and wen=0 in all cycles other than REQ-016/REQ-020 issue cycles.

Reset
REQ-024 rstn=0 SHALL asynchronously force W_IDLE, R_IDLE, and all outputs to 0 (awready, arready, wready, bvalid, rvalid, rlast, ren, wen, addresses, data, resp, id).
REQ-025 Reset mid-burst SHALL abandon the burst with no further ren/wen; after rstn rises, the first cycle SHALL present awready=1 and arready=1.

Configuration
REQ-026 Macro AXI_RAM_BRIDGE_WRAP_EN SHALL select WRAP support.
REQ-031 With AXI_RAM_BRIDGE_WRAP_EN defined, WRAP (2'b10) SHALL wrap at boundary (len+1)*step; len+1 not in {2,4,8,16} SHALL give SLVERR and be executed as INCR.
REQ-032 Without AXI_RAM_BRIDGE_WRAP_EN, WRAP SHALL be executed as INCR with resp SLVERR on B and on every R beat.

Structure
REQ-027 Package axi_ram_pkg SHALL hold the burst enum (FIXED/INCR/WRAP), resp constants (OKAY=2'b00, SLVERR=2'b10), and the write/read state enums.
REQ-028 Sub-module axi_ram_addr_gen (combinational next address from addr/burst/len/step) SHALL be instantiated once by each FSM.

Verification
REQ-029 SHALL be covered by these directed scenarios:
- AW INCR addr 0x100 len 3, four W beats, no stalls -> wen on 4 consecutive cycles, waddr 0x100/0x110/0x120/0x130, bresp OKAY.
- AR INCR addr 0x205 len 1 -> raddr 0x200 then 0x210, rdata matches RAM, rlast on beat 2 only, rresp OKAY.
- Read len 7 with rready toggling randomly at 50% -> no beat lost or duplicated, ren count = 8.
- WRAP addr 0x130 len 3 -> with macro raddr 0x130,0x100,0x110,0x120 OKAY; without macro 0x130..0x160 with SLVERR.
- Write len 3 with wlast on beat 2 -> 4 beats written, bresp SLVERR.
- rstn pulsed low during beat 2 of a len 7 read -> rvalid/ren drop immediately, arready=1 the cycle after release.
